muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage of the 5-stage MIPS core. It generalises the single-purpose 32-bit divider used there to any operand width and adds signed/unsigned multiply, divide-by-zero reporting and cancellation. The unit produces the HI/LO pair that the pipeline forwards into the hilo register path, and uses a start/ready handshake that the hazard unit stalls on.

## Interface
- WIDTH, 32: operand width W; W ≥ 4, even; HI and LO are each W bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- annul  in  1  cancel the in-flight or requested operation (pipeline flush/exception).
- op  in  2  00 DIV (signed), 01 DIVU, 10 MULT (signed), 11 MULTU.
- a  in  W  dividend / multiplicand.
- b  in  W  divisor / multiplier.
- busy  out  1  high in RUN.
- ready  out  1  one-cycle pulse: hi/lo/dbz valid.
- hi  out  W  remainder (div) or product[2W-1:W] (mul).
- lo  out  W  quotient (div) or product[W-1:0] (mul).
- dbz  out  1  divide-by-zero flag; valid with ready, held until the next ready.

## Operation
- States: IDLE, RUN, DONE.
- Accept: state IDLE or DONE, start=1, annul=0. On accept: latch op, sign flags sa=a[W-1], sb=b[W-1] (signed ops only), and |a|, |b|; clear count.
- Accept transitions:
  - Divide with b==0 → DONE directly: hi=a, lo=all ones, dbz=1.
  - Otherwise → RUN.
- Not accepted: IDLE → IDLE; DONE → IDLE.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Uses a (W+1)-bit partial remainder.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2W-bit accumulator.
- RUN ends after exactly W iterations (count 0..W-1) → DONE. The final iteration's sign-corrected result is registered into hi/lo.
- Sign correction, signed divide: quotient negated if sa^sb; remainder negated if sa.
- Sign correction, signed multiply: 2W product negated if sa^sb.
- Unsigned ops: no correction.
- Most-negative ÷ -1 gives lo = 1 followed by W-1 zeros, hi=0, dbz=0. No overflow flag.
- annul=1 in RUN → IDLE next edge. No ready; hi/lo/dbz keep their previous values.
- annul=1 with start in IDLE/DONE → nothing accepted, next state IDLE.
- start while in RUN is ignored.
- DONE lasts one cycle. ready=1 only in DONE.
- An accept in DONE gives back-to-back operation: DONE → RUN or DONE, with no IDLE gap.
- dbz clears on every ready of a non-zero-divisor operation.

## Timing
- Reset (rst low, asynchronous): state IDLE, busy=0, ready=0, hi=0, lo=0, dbz=0, count=0.
- Reset deasserted mid-operation: unit restarts in IDLE; no ready for the lost operation.
- Edge E0 is the edge that samples an accept.
- Normal latency: RUN covers cycles E0..E(W-1). ready is high in the cycle after edge E_W, so the result is visible W cycles after E0 (32 for W=32).
- Divide by zero latency: ready in the cycle after E0 (1 cycle).
- busy high exactly while in RUN. busy and ready are never both high.
- hi/lo/dbz change only at the edge entering DONE, and remain stable until the next DONE.
- Counter width: $clog2(W)+1 bits; no wrap.

## Configuration
- MULDIV_FASTMUL_EN defined: MULT/MULTU compute the 2W product with a single combinational multiplier. Accept → DONE directly, ready 1 cycle after E0, busy never asserted for multiplies.
- Undefined: multiplies use the iterative W-cycle path described above.
- Divide behaviour is identical in both builds.

## Test plan
- DIVU a=100, b=7 → ready exactly 32 cycles after accept; lo=14, hi=2, dbz=0; busy high for 32 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT a=-3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Latency is 32 cycles, or 1 with MULDIV_FASTMUL_EN.
- DIVU a=5, b=0 → ready 1 cycle after accept; hi=5, lo=0xFFFFFFFF, dbz=1. A following DIVU 9/3 → dbz=0, lo=3, hi=0.
- DIV started, annul at cycle 10 → busy low next cycle, ready never asserted, hi/lo unchanged. A new start is then accepted normally.
- start held high in the DONE cycle with new operands → second result after another 32 cycles with no IDLE gap. rst pulsed low in mid-RUN → all outputs 0 immediately, no ready.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO result, optional MULDIV_FASTMUL_EN single-cycle multiply
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             annul,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_sa;
    logic             r_sb;
    // Division: r_acc_hi = partial remainder, r_acc_lo = dividend shifting into quotient.
    // Multiply: {r_acc_hi, r_acc_lo} = product accumulator, r_acc_lo LSB is the current multiplier bit.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_div;
    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_b_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept = (r_state != S_RUN) && start && !annul;
    assign w_is_div = ~op[1];
    assign w_signed = ~op[0];
    assign w_sa     = w_signed & a[WIDTH-1];
    assign w_sb     = w_signed & b[WIDTH-1];
    assign w_abs_a  = w_sa ? (-a) : a;
    assign w_abs_b  = w_sb ? (-b) : b;
    assign w_b_zero = (b == '0);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
    assign w_shift   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_opnd};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_div_rem = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_quo = {r_acc_lo[WIDTH-2:0], w_qbit};

    // Shift-add multiply step: add multiplicand on multiplier LSB, shift accumulator right.
    assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_hi = w_sum[WIDTH:1];
    assign w_mul_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod   = {w_mul_hi, w_mul_lo};

    // Sign correction of the final iteration's result; signs are zero for unsigned ops.
    assign w_prod_fix = (r_sa ^ r_sb) ? (-w_prod) : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? (-w_div_quo) : w_div_quo;
    assign w_rem_fix  = r_sa ? (-w_div_rem) : w_div_rem;

`ifdef MULDIV_FASTMUL_EN
    logic [2*WIDTH-1:0] w_fast_raw;
    logic [2*WIDTH-1:0] w_fast_fix;
    assign w_fast_raw = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
    assign w_fast_fix = (w_sa ^ w_sb) ? (-w_fast_raw) : w_fast_raw;
`endif

    assign busy  = (r_state == S_RUN);
    assign ready = (r_state == S_DONE);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign dbz   = r_dbz;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept from IDLE/DONE, W iterations in RUN, annul aborts to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (annul) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                if (w_accept) begin
                    if (w_is_div && w_b_zero) begin
                        w_next = S_DONE;
`ifdef MULDIV_FASTMUL_EN
                    end else if (!w_is_div) begin
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_RUN;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, load results only when entering DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!annul) begin
                r_count <= r_count + CW'(1);
                if (r_is_div) begin
                    r_acc_hi <= w_div_rem;
                    r_acc_lo <= w_div_quo;
                end else begin
                    r_acc_hi <= w_mul_hi;
                    r_acc_lo <= w_mul_lo;
                end
                if (w_last) begin
                    r_dbz <= 1'b0;
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
            end
        end else if (w_accept) begin
            // Multiply is commutative, so both ops keep |a| in the shifting register and |b| fixed.
            r_count  <= '0;
            r_is_div <= w_is_div;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_acc_hi <= '0;
            r_acc_lo <= w_abs_a;
            r_opnd   <= w_abs_b;
            if (w_is_div && w_b_zero) begin
                r_hi  <= a;
                r_lo  <= '1;
                r_dbz <= 1'b1;
            end
`ifdef MULDIV_FASTMUL_EN
            if (!w_is_div) begin
                r_hi  <= w_fast_fix[2*WIDTH-1:WIDTH];
                r_lo  <= w_fast_fix[WIDTH-1:0];
                r_dbz <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

    localparam logic [1:0] OP_DIV   = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_MULTU = 2'b11;
`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_EDGE = 0;
`else
    localparam int MUL_EDGE = 32;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;
    logic        last_dbz = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .annul (annul),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .ready (ready),
        .hi    (hi),
        .lo    (lo),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready actual=1 expected=0");
            end else begin
                mon_e = q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                chk("lo", {32'd0, lo}, {32'd0, mon_e.lo});
                chk("dbz", {63'd0, dbz}, {63'd0, mon_e.dbz});
                chk("busy_with_ready", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Issue one operation starting at a negedge; returns at the negedge where ready is seen.
    // edge_k: ready is expected in the cycle after edge E_k (E0 = accepting edge).
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int edge_k);
        exp_t e;
        int   lat;
        int   nbusy;
        bit   got;
        e.hi = eh;
        e.lo = el;
        e.dbz = ed;
        q.push_back(e);
        last_hi  = eh;
        last_lo  = el;
        last_dbz = ed;
        op = o;
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        nbusy = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (ready) got = 1'b1;
        end
        chk({name, "_ready_edge"}, 64'(lat - 1), 64'(edge_k));
        chk({name, "_busy_cycles"}, 64'(nbusy), 64'(edge_k));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nready;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_dbz", {63'd0, dbz}, 64'd0);
        rst = 1'b1;
        idle(2);

        // back-to-back: second start held in the DONE cycle
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32);
        idle(2);
        issue("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 32);
        idle(2);
        issue("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_EDGE);
        issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_EDGE);
        idle(2);
        issue("divu_dbz", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 0);
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32);
        idle(3);
        issue("mult_m4_m6", OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'd0, 32'd24, 1'b0, MUL_EDGE);
        idle(1);
        issue("div_dbz_neg", OP_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 0);
        idle(2);

        // annul at cycle 10 of a divide
        op = OP_DIV;
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("annul_busy_before", {63'd0, busy}, 64'd1);
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        chk("annul_busy_after", {63'd0, busy}, 64'd0);
        chk("annul_hi_kept", {32'd0, hi}, {32'd0, last_hi});
        chk("annul_lo_kept", {32'd0, lo}, {32'd0, last_lo});
        chk("annul_dbz_kept", {63'd0, dbz}, {63'd0, last_dbz});
        nready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) nready++;
        end
        chk("annul_no_ready", 64'(nready), 64'd0);
        issue("divu_after_annul", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        idle(2);

        // asynchronous reset in mid-RUN
        op = OP_DIVU;
        a = 32'd77;
        b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_ready", {63'd0, ready}, 64'd0);
        chk("mrst_hi", {32'd0, hi}, 64'd0);
        chk("mrst_lo", {32'd0, lo}, 64'd0);
        chk("mrst_dbz", {63'd0, dbz}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        nready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) nready++;
        end
        chk("mrst_no_ready", 64'(nready), 64'd0);
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 32);
        idle(3);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
